// File: rtl/morse_encoder.sv
// Morse encoder for letters A..H.
// A Start rising edge loads the selected letter's left-aligned pattern into a
// 12-bit shift register; each Morse unit lasts TICK_COUNT cycles, after which
// the register shifts left and the remaining length is decremented.
// Out is the shift register MSB and Busy is the SEND state. Both come straight
// from flops, so nothing combinational connects the inputs to the outputs.
module morse_encoder #(
  parameter int TICK_COUNT = 25000000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [2:0] Letter,
  input  logic       Start,
  output logic       Out,
  output logic       Busy
);

  localparam int TW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_COUNT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [11:0]   shift_q, shift_d;
  logic [3:0]    len_q, len_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          start_q;

  logic [11:0]   pat_bits;
  logic [3:0]    pat_len;
  logic          start_rise;

  // Pattern table: left-aligned unit stream and its length in units.
  always_comb begin
    pat_bits = 12'h000;
    pat_len  = 4'd0;
    case (Letter)
      3'd0: begin pat_bits = 12'hB80; pat_len = 4'd5;  end // A .-
      3'd1: begin pat_bits = 12'hEA8; pat_len = 4'd9;  end // B -...
      3'd2: begin pat_bits = 12'hEBA; pat_len = 4'd11; end // C -.-.
      3'd3: begin pat_bits = 12'hEA0; pat_len = 4'd7;  end // D -..
      3'd4: begin pat_bits = 12'h800; pat_len = 4'd1;  end // E .
      3'd5: begin pat_bits = 12'hAE8; pat_len = 4'd9;  end // F ..-.
      3'd6: begin pat_bits = 12'hEE8; pat_len = 4'd9;  end // G --.
      3'd7: begin pat_bits = 12'hAA0; pat_len = 4'd7;  end // H ....
      default: begin pat_bits = 12'h000; pat_len = 4'd0; end
    endcase
  end

  // A trigger needs Start high now and low on the previous cycle.
  assign start_rise = Start & ~start_q;

  // Next-state logic: load on a trigger in IDLE, step one unit per terminal tick in SEND.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    len_d   = len_q;
    tick_d  = tick_q;
    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          shift_d = pat_bits;
          len_d   = pat_len;
          tick_d  = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (len_q == 4'd1) begin
            // Last unit done: drop straight to IDLE with nothing left in the register.
            state_d = S_IDLE;
            shift_d = 12'h000;
            len_d   = 4'd0;
          end else begin
            shift_d = {shift_q[10:0], 1'b0};
            len_d   = len_q - 4'd1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        shift_d = 12'h000;
        len_d   = 4'd0;
        tick_d  = '0;
      end
    endcase
  end

  // State registers; reset wins over everything, Start history always tracks the input.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      shift_q <= 12'h000;
      len_q   <= 4'd0;
      tick_q  <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      len_q   <= len_d;
      tick_q  <= tick_d;
      start_q <= Start;
    end
  end

  assign Out  = shift_q[11];
  assign Busy = (state_q == S_SEND);

endmodule
